// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite arbiter and its grant selector.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4
  } state_e;

  localparam int RESP_OKAY   = 0;
  localparam int RESP_SLVERR = 2;

  typedef logic [0:0] gnt_idx_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-request round-robin selector; ptr names the requester that wins a tie.
module rr_grant2
  import axi_lite_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_idx_t   ptr,
  output gnt_idx_t   gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = ptr;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ptr;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter, one transaction in flight at a time.
//
// state        | meaning
// IDLE         | pick requester (round-robin) and op (write/read), register grant
// WR_ADDR_DATA | AW and W forwarded from granted master until both handshake
// WR_RESP      | B forwarded back to granted master
// RD_ADDR      | AR forwarded from granted master
// RD_DATA      | R forwarded back to granted master
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,

  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0] s0_axi_wstrb,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [RESP_WIDTH-1:0] s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [RESP_WIDTH-1:0] s0_axi_rresp,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,

  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [DATA_WIDTH/8:0] s1_axi_wstrb,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [RESP_WIDTH-1:0] s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [RESP_WIDTH-1:0] s1_axi_rresp,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,

  output logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
  output logic                  m0_axi_awvalid,
  input  logic                  m0_axi_awready,
  output logic [DATA_WIDTH-1:0] m0_axi_wdata,
  output logic [DATA_WIDTH/8:0] m0_axi_wstrb,
  output logic                  m0_axi_wvalid,
  input  logic                  m0_axi_wready,
  input  logic [RESP_WIDTH-1:0] m0_axi_bresp,
  input  logic                  m0_axi_bvalid,
  output logic                  m0_axi_bready,
  output logic [ADDR_WIDTH-1:0] m0_axi_araddr,
  output logic                  m0_axi_arvalid,
  input  logic                  m0_axi_arready,
  input  logic [DATA_WIDTH-1:0] m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m0_axi_rresp,
  input  logic                  m0_axi_rvalid,
  output logic                  m0_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8 + 1;

  logic [1:0] rst_sync;
  logic       rst_n;

  state_e   state;
  gnt_idx_t gnt;
  gnt_idx_t rr_ptr;
  gnt_idx_t sel;
  logic     sel_any;
  logic     is_write;
  logic     prefer_read;
  logic     aw_done;
  logic     w_done;

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic       sel_wr;
  logic       sel_rd;
  logic       take_write;

  logic in_wa, in_wb, in_ra, in_rd;
  logic sel0, sel1;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [ADDR_WIDTH-1:0] g_awaddr;
  logic [ADDR_WIDTH-1:0] g_araddr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [STRB_WIDTH-1:0] g_wstrb;
  logic                  g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

  // Reset asserts asynchronously but is released on a clock edge inside the block.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign wr_req = {s1_axi_awvalid, s0_axi_awvalid};
  assign rd_req = {s1_axi_arvalid, s0_axi_arvalid};

  rr_grant2 u_rr_grant2 (
    .req (wr_req | rd_req),
    .ptr (rr_ptr),
    .gnt (sel),
    .any (sel_any)
  );

  assign sel_wr     = wr_req[sel];
  assign sel_rd     = rd_req[sel];
  assign take_write = sel_wr & ~(sel_rd & prefer_read);

  assign in_wa = (state == WR_ADDR_DATA);
  assign in_wb = (state == WR_RESP);
  assign in_ra = (state == RD_ADDR);
  assign in_rd = (state == RD_DATA);
  assign sel0  = (gnt == 1'b0);
  assign sel1  = (gnt == 1'b1);

  assign g_awaddr  = sel1 ? s1_axi_awaddr  : s0_axi_awaddr;
  assign g_awvalid = sel1 ? s1_axi_awvalid : s0_axi_awvalid;
  assign g_wdata   = sel1 ? s1_axi_wdata   : s0_axi_wdata;
  assign g_wstrb   = sel1 ? s1_axi_wstrb   : s0_axi_wstrb;
  assign g_wvalid  = sel1 ? s1_axi_wvalid  : s0_axi_wvalid;
  assign g_bready  = sel1 ? s1_axi_bready  : s0_axi_bready;
  assign g_araddr  = sel1 ? s1_axi_araddr  : s0_axi_araddr;
  assign g_arvalid = sel1 ? s1_axi_arvalid : s0_axi_arvalid;
  assign g_rready  = sel1 ? s1_axi_rready  : s0_axi_rready;

  // A channel that already handshook is masked so the target never sees it twice.
  assign m0_axi_awvalid = in_wa & g_awvalid & ~aw_done;
  assign m0_axi_awaddr  = in_wa ? g_awaddr : '0;
  assign m0_axi_wvalid  = in_wa & g_wvalid & ~w_done;
  assign m0_axi_wdata   = in_wa ? g_wdata : '0;
  assign m0_axi_wstrb   = in_wa ? g_wstrb : '0;
  assign m0_axi_bready  = in_wb & g_bready;
  assign m0_axi_arvalid = in_ra & g_arvalid;
  assign m0_axi_araddr  = in_ra ? g_araddr : '0;
  assign m0_axi_rready  = in_rd & g_rready;

  assign s0_axi_awready = in_wa & sel0 & ~aw_done & m0_axi_awready;
  assign s0_axi_wready  = in_wa & sel0 & ~w_done & m0_axi_wready;
  assign s0_axi_bvalid  = in_wb & sel0 & m0_axi_bvalid;
  assign s0_axi_bresp   = (in_wb & sel0) ? m0_axi_bresp : '0;
  assign s0_axi_arready = in_ra & sel0 & m0_axi_arready;
  assign s0_axi_rvalid  = in_rd & sel0 & m0_axi_rvalid;
  assign s0_axi_rdata   = (in_rd & sel0) ? m0_axi_rdata : '0;
  assign s0_axi_rresp   = (in_rd & sel0) ? m0_axi_rresp : '0;

  assign s1_axi_awready = in_wa & sel1 & ~aw_done & m0_axi_awready;
  assign s1_axi_wready  = in_wa & sel1 & ~w_done & m0_axi_wready;
  assign s1_axi_bvalid  = in_wb & sel1 & m0_axi_bvalid;
  assign s1_axi_bresp   = (in_wb & sel1) ? m0_axi_bresp : '0;
  assign s1_axi_arready = in_ra & sel1 & m0_axi_arready;
  assign s1_axi_rvalid  = in_rd & sel1 & m0_axi_rvalid;
  assign s1_axi_rdata   = (in_rd & sel1) ? m0_axi_rdata : '0;
  assign s1_axi_rresp   = (in_rd & sel1) ? m0_axi_rresp : '0;

  assign aw_hs = m0_axi_awvalid & m0_axi_awready;
  assign w_hs  = m0_axi_wvalid  & m0_axi_wready;
  assign b_hs  = m0_axi_bvalid  & m0_axi_bready;
  assign ar_hs = m0_axi_arvalid & m0_axi_arready;
  assign r_hs  = m0_axi_rvalid  & m0_axi_rready;

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      is_write    <= 1'b0;
      rr_ptr      <= 1'b0;
      prefer_read <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            gnt      <= sel;
            is_write <= take_write;
            state    <= take_write ? WR_ADDR_DATA : RD_ADDR;
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rr_ptr      <= ~gnt;
            prefer_read <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (ar_hs) state <= RD_DATA;
        end
        RD_DATA: begin
          if (r_hs) begin
            state       <= IDLE;
            rr_ptr      <= ~gnt;
            prefer_read <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: two cycle-stepped masters and a simple target model.
module tb_axi_lite_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW / 8 + 1;

  logic axi_aclk = 1'b0;
  logic axi_aresetn;
  always #5 axi_aclk = ~axi_aclk;

  logic [AW-1:0] awaddr_s [2];
  logic          awvalid_s[2];
  logic [DW-1:0] wdata_s  [2];
  logic [SW-1:0] wstrb_s  [2];
  logic          wvalid_s [2];
  logic          bready_s [2];
  logic [AW-1:0] araddr_s [2];
  logic          arvalid_s[2];
  logic          rready_s [2];

  logic          awready_o[2];
  logic          wready_o [2];
  logic [RW-1:0] bresp_o  [2];
  logic          bvalid_o [2];
  logic          arready_o[2];
  logic [DW-1:0] rdata_o  [2];
  logic [RW-1:0] rresp_o  [2];
  logic          rvalid_o [2];

  logic [AW-1:0] m_awaddr, m_araddr;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          t_awready, t_wready, t_bvalid, t_arready, t_rvalid;
  logic [RW-1:0] t_bresp, t_rresp;
  logic [DW-1:0] t_rdata;

  axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .axi_aclk       (axi_aclk),
    .axi_aresetn    (axi_aresetn),
    .s0_axi_awaddr  (awaddr_s[0]),  .s0_axi_awvalid (awvalid_s[0]), .s0_axi_awready (awready_o[0]),
    .s0_axi_wdata   (wdata_s[0]),   .s0_axi_wstrb   (wstrb_s[0]),   .s0_axi_wvalid  (wvalid_s[0]),
    .s0_axi_wready  (wready_o[0]),  .s0_axi_bresp   (bresp_o[0]),   .s0_axi_bvalid  (bvalid_o[0]),
    .s0_axi_bready  (bready_s[0]),  .s0_axi_araddr  (araddr_s[0]),  .s0_axi_arvalid (arvalid_s[0]),
    .s0_axi_arready (arready_o[0]), .s0_axi_rdata   (rdata_o[0]),   .s0_axi_rresp   (rresp_o[0]),
    .s0_axi_rvalid  (rvalid_o[0]),  .s0_axi_rready  (rready_s[0]),
    .s1_axi_awaddr  (awaddr_s[1]),  .s1_axi_awvalid (awvalid_s[1]), .s1_axi_awready (awready_o[1]),
    .s1_axi_wdata   (wdata_s[1]),   .s1_axi_wstrb   (wstrb_s[1]),   .s1_axi_wvalid  (wvalid_s[1]),
    .s1_axi_wready  (wready_o[1]),  .s1_axi_bresp   (bresp_o[1]),   .s1_axi_bvalid  (bvalid_o[1]),
    .s1_axi_bready  (bready_s[1]),  .s1_axi_araddr  (araddr_s[1]),  .s1_axi_arvalid (arvalid_s[1]),
    .s1_axi_arready (arready_o[1]), .s1_axi_rdata   (rdata_o[1]),   .s1_axi_rresp   (rresp_o[1]),
    .s1_axi_rvalid  (rvalid_o[1]),  .s1_axi_rready  (rready_s[1]),
    .m0_axi_awaddr  (m_awaddr),     .m0_axi_awvalid (m_awvalid),    .m0_axi_awready (t_awready),
    .m0_axi_wdata   (m_wdata),      .m0_axi_wstrb   (m_wstrb),      .m0_axi_wvalid  (m_wvalid),
    .m0_axi_wready  (t_wready),     .m0_axi_bresp   (t_bresp),      .m0_axi_bvalid  (t_bvalid),
    .m0_axi_bready  (m_bready),     .m0_axi_araddr  (m_araddr),     .m0_axi_arvalid (m_arvalid),
    .m0_axi_arready (t_arready),    .m0_axi_rdata   (t_rdata),      .m0_axi_rresp   (t_rresp),
    .m0_axi_rvalid  (t_rvalid),     .m0_axi_rready  (m_rready)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int            bcnt[2];
  int            rcnt[2];
  logic [RW-1:0] last_bresp[2];
  logic [DW-1:0] last_rdata[2];
  logic [RW-1:0] last_rresp[2];
  logic [AW-1:0] cap_aw[$];
  logic [DW-1:0] cap_w[$];

  logic          aw_seen, w_seen, rd_pend, t_bhold;
  int            rd_cnt, rd_delay;
  logic [RW-1:0] tgt_bresp, tgt_rresp;
  logic [DW-1:0] tgt_rdata;

  logic mon_s1_en, mon_aw1_en;
  int   s1_act, aw1_viol, aw1_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] hs_vec();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            awready_o[0], wready_o[0], bvalid_o[0], arready_o[0], rvalid_o[0],
            awready_o[1], wready_o[1], bvalid_o[1], arready_o[1], rvalid_o[1]};
  endfunction

  // One clock: sample handshakes at the falling edge, update masters/target after the rising edge.
  task automatic step();
    logic aw_hs[2], w_hs[2], b_hs[2], ar_hs[2], r_hs[2];
    logic taw, tw, tbh, tar, tr;
    @(negedge axi_aclk);
    for (int i = 0; i < 2; i++) begin
      aw_hs[i] = awvalid_s[i] & awready_o[i];
      w_hs[i]  = wvalid_s[i] & wready_o[i];
      b_hs[i]  = bvalid_o[i] & bready_s[i];
      ar_hs[i] = arvalid_s[i] & arready_o[i];
      r_hs[i]  = rvalid_o[i] & rready_s[i];
      if (b_hs[i]) last_bresp[i] = bresp_o[i];
      if (r_hs[i]) begin
        last_rdata[i] = rdata_o[i];
        last_rresp[i] = rresp_o[i];
      end
    end
    if (mon_s1_en && (awready_o[1] | wready_o[1] | bvalid_o[1] | arready_o[1] | rvalid_o[1]))
      s1_act++;
    if (mon_aw1_en && awready_o[1] && bcnt[0] == aw1_base) aw1_viol++;
    taw = m_awvalid & t_awready;
    tw  = m_wvalid & t_wready;
    tbh = t_bvalid & m_bready;
    tar = m_arvalid & t_arready;
    tr  = t_rvalid & m_rready;
    if (taw) cap_aw.push_back(m_awaddr);
    if (tw)  cap_w.push_back(m_wdata);
    @(posedge axi_aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (aw_hs[i]) awvalid_s[i] = 1'b0;
      if (w_hs[i])  wvalid_s[i]  = 1'b0;
      if (ar_hs[i]) arvalid_s[i] = 1'b0;
      if (b_hs[i])  bcnt[i]++;
      if (r_hs[i])  rcnt[i]++;
    end
    if (tbh) t_bvalid = 1'b0;
    if (taw) aw_seen = 1'b1;
    if (tw)  w_seen  = 1'b1;
    if (aw_seen && w_seen && !t_bvalid && !t_bhold) begin
      t_bvalid = 1'b1;
      t_bresp  = tgt_bresp;
      aw_seen  = 1'b0;
      w_seen   = 1'b0;
    end
    if (tr) t_rvalid = 1'b0;
    if (tar) begin
      rd_pend = 1'b1;
      rd_cnt  = rd_delay;
    end else if (rd_pend) begin
      if (rd_cnt == 0) begin
        t_rvalid = 1'b1;
        t_rdata  = tgt_rdata;
        t_rresp  = tgt_rresp;
        rd_pend  = 1'b0;
      end else begin
        rd_cnt--;
      end
    end
  endtask

  task automatic start_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
    awaddr_s[i]  = a;
    awvalid_s[i] = 1'b1;
    wdata_s[i]   = d;
    wstrb_s[i]   = s;
    wvalid_s[i]  = 1'b1;
  endtask

  task automatic start_rd(input int i, input logic [AW-1:0] a);
    araddr_s[i]  = a;
    arvalid_s[i] = 1'b1;
  endtask

  task automatic wait_b(input int i, input int n);
    for (int k = 0; k < 100 && bcnt[i] < n; k++) step();
  endtask

  task automatic wait_r(input int i, input int n);
    for (int k = 0; k < 100 && rcnt[i] < n; k++) step();
  endtask

  initial begin
    int b0, b1, r0, r1;
    axi_aresetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awaddr_s[i] = 8'hFF; awvalid_s[i] = 1'b0; wdata_s[i] = 32'hFFFF_FFFF;
      wstrb_s[i] = '1; wvalid_s[i] = 1'b0; bready_s[i] = 1'b1;
      araddr_s[i] = 8'hFF; arvalid_s[i] = 1'b0; rready_s[i] = 1'b1;
      bcnt[i] = 0; rcnt[i] = 0; last_bresp[i] = '0; last_rdata[i] = '0; last_rresp[i] = '0;
    end
    t_awready = 1'b1; t_wready = 1'b1; t_arready = 1'b1;
    t_bvalid = 1'b1; t_bresp = 3'd3; t_rvalid = 1'b1; t_rdata = 32'hDEAD_BEEF; t_rresp = 3'd3;
    aw_seen = 1'b0; w_seen = 1'b0; rd_pend = 1'b0; t_bhold = 1'b0;
    rd_cnt = 0; rd_delay = 3; tgt_bresp = 3'd0; tgt_rresp = 3'd0; tgt_rdata = '0;
    mon_s1_en = 1'b0; mon_aw1_en = 1'b0; s1_act = 0; aw1_viol = 0; aw1_base = 0;

    #2 axi_aresetn = 1'b0;
    #1;
    chk("reset_handshakes", 32'(hs_vec()), 32'd0);
    chk("reset_data", 32'(|{m_awaddr, m_wdata, m_wstrb, m_araddr, rdata_o[0], rdata_o[1],
                            rresp_o[0], rresp_o[1], bresp_o[0], bresp_o[1]}), 32'd0);
    t_bvalid = 1'b0; t_rvalid = 1'b0; t_bresp = '0; t_rresp = '0;
    repeat (2) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    repeat (3) step();

    // single s0 write
    mon_s1_en = 1'b1;
    start_wr(0, 8'h04, 32'd56, 5'h0F);
    #2;
    chk("idle_no_forward", 32'(m_awvalid), 32'd0);
    chk("idle_no_awready", 32'(awready_o[0]), 32'd0);
    step();
    #2;
    chk("wr1_awvalid", 32'(m_awvalid), 32'd1);
    chk("wr1_awaddr", 32'(m_awaddr), 32'h04);
    chk("wr1_wdata", m_wdata, 32'd56);
    chk("wr1_wstrb", 32'(m_wstrb), 32'h0F);
    wait_b(0, 1);
    chk("wr1_bcnt", 32'(bcnt[0]), 32'd1);
    chk("wr1_bresp", 32'(last_bresp[0]), 32'd0);
    chk("wr1_s1_quiet", 32'(s1_act), 32'd0);
    mon_s1_en = 1'b0;

    // s1 read with delayed target data
    tgt_rdata = 32'd49; tgt_rresp = 3'd0;
    start_rd(1, 8'h08);
    step();
    #2;
    chk("rd1_arvalid", 32'(m_arvalid), 32'd1);
    chk("rd1_araddr", 32'(m_araddr), 32'h08);
    step();
    #2;
    chk("rd1_ar_dropped", 32'(m_arvalid), 32'd0);
    chk("rd1_rready_fwd", 32'(m_rready), 32'd1);
    wait_r(1, 1);
    chk("rd1_rcnt", 32'(rcnt[1]), 32'd1);
    chk("rd1_rdata", last_rdata[1], 32'd49);
    chk("rd1_rresp", 32'(last_rresp[1]), 32'd0);
    #2;
    chk("rd1_back_idle", 32'(m_rready), 32'd0);

    // simultaneous writes: pointer is at s0 after the s1 read
    cap_aw.delete(); cap_w.delete();
    b0 = bcnt[0]; b1 = bcnt[1];
    aw1_base = b0; aw1_viol = 0; mon_aw1_en = 1'b1;
    start_wr(0, 8'h00, 32'd56, 5'h0F);
    start_wr(1, 8'h10, 32'd64, 5'h0F);
    wait_b(1, b1 + 1);
    mon_aw1_en = 1'b0;
    chk("wr2_s0_done", 32'(bcnt[0]), 32'(b0 + 1));
    chk("wr2_s1_done", 32'(bcnt[1]), 32'(b1 + 1));
    chk("wr2_n_aw", 32'(cap_aw.size()), 32'd2);
    if (cap_aw.size() == 2 && cap_w.size() == 2) begin
      chk("wr2_first_addr", 32'(cap_aw[0]), 32'h00);
      chk("wr2_first_data", cap_w[0], 32'd56);
      chk("wr2_second_addr", 32'(cap_aw[1]), 32'h10);
      chk("wr2_second_data", cap_w[1], 32'd64);
    end
    chk("wr2_no_s1_awready", 32'(aw1_viol), 32'd0);

    // simultaneous reads: s0 must win, showing the pointer returned to s0
    tgt_rdata = 32'h33;
    r0 = rcnt[0]; r1 = rcnt[1];
    start_rd(0, 8'h14);
    start_rd(1, 8'h18);
    wait_r(0, r0 + 1);
    chk("rr_s0_first", 32'(rcnt[1]), 32'(r1));
    wait_r(1, r1 + 1);
    chk("rr_s1_second", 32'(rcnt[1]), 32'(r1 + 1));

    // s0 write+read together with prefer_read clear: write goes first
    tgt_rdata = 32'h77; tgt_rresp = 3'd2;
    b0 = bcnt[0]; r0 = rcnt[0];
    start_wr(0, 8'h24, 32'h99, 5'h0F);
    start_rd(0, 8'h28);
    wait_b(0, b0 + 1);
    chk("pair1_write_first", 32'(rcnt[0]), 32'(r0));
    wait_r(0, r0 + 1);
    chk("pair1_read_done", 32'(rcnt[0]), 32'(r0 + 1));
    chk("pair1_rdata", last_rdata[0], 32'h77);
    chk("pair1_rresp", 32'(last_rresp[0]), 32'd2);

    // after a write, a new write+read pair starts with the read
    b0 = bcnt[0];
    start_wr(0, 8'h2C, 32'h5, 5'h01);
    wait_b(0, b0 + 1);
    b0 = bcnt[0]; r0 = rcnt[0];
    start_wr(0, 8'h30, 32'h6, 5'h01);
    start_rd(0, 8'h34);
    wait_r(0, r0 + 1);
    chk("pair2_read_first", 32'(bcnt[0]), 32'(b0));
    wait_b(0, b0 + 1);
    chk("pair2_write_done", 32'(bcnt[0]), 32'(b0 + 1));

    // AW accepted while W stalls at the target
    tgt_bresp = 3'd2;
    t_wready = 1'b0;
    b0 = bcnt[0];
    start_wr(0, 8'h0C, 32'hA5, 5'h0F);
    step();
    #2;
    chk("wstall_aw_fwd", 32'(m_awvalid), 32'd1);
    step();
    #2;
    chk("wstall_aw_dropped", 32'(m_awvalid), 32'd0);
    chk("wstall_w_held", 32'(m_wvalid), 32'd1);
    repeat (2) step();
    #2;
    chk("wstall_w_still", 32'(m_wvalid), 32'd1);
    chk("wstall_no_awready", 32'(awready_o[0]), 32'd0);
    t_wready = 1'b1;
    wait_b(0, b0 + 1);
    repeat (3) step();
    chk("wstall_one_b", 32'(bcnt[0]), 32'(b0 + 1));
    chk("wstall_bresp", 32'(last_bresp[0]), 32'd2);
    tgt_bresp = 3'd0;

    // reset while waiting for B
    t_bhold = 1'b1;
    start_wr(0, 8'h40, 32'h1, 5'h01);
    for (int k = 0; k < 50 && (awvalid_s[0] || wvalid_s[0]); k++) step();
    #1;
    chk("rst_mid_in_wresp", 32'(m_bready), 32'd1);
    axi_aresetn = 1'b0;
    #1;
    chk("rst_mid_handshakes", 32'(hs_vec()), 32'd0);
    aw_seen = 1'b0; w_seen = 1'b0; rd_pend = 1'b0; t_bhold = 1'b0;
    t_bvalid = 1'b0; t_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      awvalid_s[i] = 1'b0; wvalid_s[i] = 1'b0; arvalid_s[i] = 1'b0;
    end
    repeat (2) @(posedge axi_aclk);
    #1 axi_aresetn = 1'b1;
    repeat (3) step();
    cap_aw.delete(); cap_w.delete();
    b0 = bcnt[0]; b1 = bcnt[1];
    start_wr(0, 8'h20, 32'h11, 5'h0F);
    start_wr(1, 8'h30, 32'h22, 5'h0F);
    wait_b(0, b0 + 1);
    chk("post_rst_s0_first", 32'(bcnt[1]), 32'(b1));
    wait_b(1, b1 + 1);
    chk("post_rst_s1_done", 32'(bcnt[1]), 32'(b1 + 1));
    chk("post_rst_s0_once", 32'(bcnt[0]), 32'(b0 + 1));
    if (cap_aw.size() == 2) chk("post_rst_s1_addr", 32'(cap_aw[1]), 32'h30);
    else chk("post_rst_n_aw", 32'(cap_aw.size()), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
